prog_load_ctrl: RTL and testbench
=================================

# prog_load_ctrl

Sequences program download into instruction memory. It accepts the byte stream from the program loader (start/end markers plus per-byte valid strobes), assembles big-endian 32-bit words and writes them to consecutive instruction-memory addresses. It holds the CPU fetch path disabled for the whole download and re-enables it once the last word is committed. It sits between the serial/loader front end and the instruction memory write port, beside the fetch stage.

## Interface
- INST_MEM_WIDTH, 2, instruction-memory word-address width; capacity = 2**INST_MEM_WIDTH words
- CLK  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- input_data  in  8  loader byte
- input_valid  in  1  one-cycle strobe: input_data valid this cycle
- input_start  in  1  one-cycle strobe: begin download
- input_end  in  1  one-cycle strobe: end download
- mem_we  out  1  instruction-memory write enable, one cycle per word
- mem_addr  out  INST_MEM_WIDTH  write word address
- mem_wdata  out  32  write data
- cpu_enable  out  1  fetch enable; 0 while loading
- loading  out  1  1 in LOAD or DRAIN
- word_count  out  INST_MEM_WIDTH+1  words written by current/last download
- err_partial  out  1  sticky: download ended with 1-3 leftover bytes
- err_overflow  out  1  sticky: more words than memory capacity

## Operation
- States: RUN, LOAD, DRAIN. Reset → RUN.
- Reset values: cpu_enable=1, loading=0, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, err_partial=0, err_overflow=0, byte index=0, assembly register=0.
- RUN: input_valid and input_end ignored. input_start → LOAD; clears word_count, byte index, both error flags; cpu_enable=0 from the next cycle.
- LOAD: each input_valid shifts a byte in. First byte → bits [31:24], fourth byte → [7:0]. The byte index is a 2-bit counter that wraps 3→0.
- Fourth byte accepted: if word_count < 2**INST_MEM_WIDTH, issue a write with mem_addr = word_count[INST_MEM_WIDTH-1:0] and mem_wdata = the assembled word. Otherwise drop the word and set err_overflow.
- input_end in LOAD → DRAIN. A byte presented with input_valid in the same cycle is accepted first, and may complete a word.
- DRAIN: one cycle. If byte index ≠ 0, set err_partial and discard the leftover bytes (no padding write). Byte index is cleared. Next state is RUN.
- input_start in LOAD or DRAIN restarts: clears counters and flags, discards the partial word, returns to LOAD. input_start wins over a simultaneous input_end. input_valid in the same cycle as input_start is ignored.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Reset mid-download aborts immediately. No further mem_we; all outputs take their reset values.

## Timing
- All outputs are registered.
- Byte accepted at edge k completes a word → mem_we=1 during cycle k+1 (exactly one cycle). word_count increments at edge k+1.
- Back-to-back bytes on every cycle are supported: one write per 4 cycles, no stall.
- input_start at edge k: cpu_enable=0 and loading=1 during cycle k+1.
- input_end at edge k: DRAIN during cycle k+1. err_partial is visible in cycle k+2. cpu_enable=1 and loading=0 during cycle k+2.
- A final word completed by the byte at the input_end edge is written in the DRAIN cycle, before cpu_enable rises.
- Error flags hold until the next input_start or reset.
- word_count saturates at 2**INST_MEM_WIDTH.

## Test plan
- Basic load: start, bytes 12 34 56 78 9A BC DE F0, end → writes addr0=0x12345678 and addr1=0x9ABCDEF0; word_count=2; cpu_enable low from start+1 until end+2; no error flags.
- Partial: start, bytes AA BB CC DD EE, end → one write (0xAABBCCDD); err_partial=1 from end+2; word_count=1.
- Overflow (INST_MEM_WIDTH=2): 20 bytes → 4 writes to addr 0-3; fifth word not written; err_overflow=1; word_count=4.
- Simultaneous events: fourth byte with input_end → write occurs in the DRAIN cycle. input_start with input_end mid-load → restart, word_count=0, no DRAIN.
- Reset mid-load after 6 bytes → no further mem_we; cpu_enable=1 and all outputs at reset values the next cycle.
- Idle noise: input_valid and input_end pulses in RUN → no mem_we, no state change.

Source files
------------

// File: rtl/prog_load_if.sv
// Loader byte stream and instruction-memory write port of the program download
// controller, bundled with master (loader/bench) and slave (controller) views.
interface prog_load_if #(
   parameter int INST_MEM_WIDTH = 2
);
   logic [7:0]                input_data;
   logic                      input_valid;
   logic                      input_start;
   logic                      input_end;
   logic                      mem_we;
   logic [INST_MEM_WIDTH-1:0] mem_addr;
   logic [31:0]               mem_wdata;
   logic                      cpu_enable;
   logic                      loading;
   logic [INST_MEM_WIDTH:0]   word_count;
   logic                      err_partial;
   logic                      err_overflow;

   modport master (
      output input_data, input_valid, input_start, input_end,
      input  mem_we, mem_addr, mem_wdata, cpu_enable, loading,
      input  word_count, err_partial, err_overflow
   );

   modport slave (
      input  input_data, input_valid, input_start, input_end,
      output mem_we, mem_addr, mem_wdata, cpu_enable, loading,
      output word_count, err_partial, err_overflow
   );
endinterface

// File: rtl/prog_load_ctrl.sv
// Program download sequencer: packs loader bytes into big-endian 32-bit words,
// writes them to consecutive instruction-memory addresses and gates CPU fetch.
module prog_load_ctrl #(
   parameter int INST_MEM_WIDTH = 2
) (
   input  logic        CLK,
   input  logic        reset,
   prog_load_if.slave  bus
);

   localparam logic [INST_MEM_WIDTH:0] LP_CAP = {1'b1, {INST_MEM_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      w_accept;
   logic                      w_clear;
   logic                      w_drain;
   logic                      w_word_done;
   logic [31:0]               w_word;

   logic [1:0]                r_byte_idx;
   logic [23:0]               r_asm;
   logic                      r_mem_we;
   logic [INST_MEM_WIDTH-1:0] r_mem_addr;
   logic [31:0]               r_mem_wdata;
   logic                      r_cpu_enable;
   logic                      r_loading;
   logic [INST_MEM_WIDTH:0]   r_word_count;
   logic                      r_err_partial;
   logic                      r_err_overflow;

   function automatic logic [INST_MEM_WIDTH:0] sat_inc(input logic [INST_MEM_WIDTH:0] v);
      return (v >= LP_CAP) ? LP_CAP : v + (INST_MEM_WIDTH+1)'(1);
   endfunction

   always_ff @(posedge CLK) begin
      if (reset) r_state <= ST_RUN;
      else       r_state <= w_state_nxt;
   end

   // input_start restarts from any state and beats a simultaneous input_end
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_clear     = 1'b0;
      w_drain     = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (bus.input_start) begin
               w_state_nxt = ST_LOAD;
               w_clear     = 1'b1;
            end
         end
         ST_LOAD: begin
            if (bus.input_start) begin
               w_clear = 1'b1;
            end else begin
               w_accept = bus.input_valid;
               if (bus.input_end) w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus.input_start) begin
               w_state_nxt = ST_LOAD;
               w_clear     = 1'b1;
            end else begin
               w_state_nxt = ST_RUN;
               w_drain     = 1'b1;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign w_word_done = w_accept && (r_byte_idx == 2'd3);
   assign w_word      = {r_asm, bus.input_data};

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_byte_idx     <= 2'd0;
         r_asm          <= 24'd0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= 32'd0;
         r_cpu_enable   <= 1'b1;
         r_loading      <= 1'b0;
         r_word_count   <= '0;
         r_err_partial  <= 1'b0;
         r_err_overflow <= 1'b0;
      end else begin
         r_mem_we     <= 1'b0;
         r_cpu_enable <= (w_state_nxt == ST_RUN);
         r_loading    <= (w_state_nxt != ST_RUN);
         // Count the write being presented this cycle; a restart overrides it below
         if (r_mem_we) r_word_count <= sat_inc(r_word_count);
         if (w_clear) begin
            r_byte_idx     <= 2'd0;
            r_asm          <= 24'd0;
            r_word_count   <= '0;
            r_err_partial  <= 1'b0;
            r_err_overflow <= 1'b0;
         end else begin
            if (w_accept) begin
               r_byte_idx <= r_byte_idx + 2'd1;
               r_asm      <= w_word[23:0];
               if (w_word_done) begin
                  if (r_word_count < LP_CAP) begin
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= r_word_count[INST_MEM_WIDTH-1:0];
                     r_mem_wdata <= w_word;
                  end else begin
                     r_err_overflow <= 1'b1;
                  end
               end
            end
            if (w_drain) begin
               if (r_byte_idx != 2'd0) r_err_partial <= 1'b1;
               r_byte_idx <= 2'd0;
            end
         end
      end
   end

   assign bus.mem_we       = r_mem_we;
   assign bus.mem_addr     = r_mem_addr;
   assign bus.mem_wdata    = r_mem_wdata;
   assign bus.cpu_enable   = r_cpu_enable;
   assign bus.loading      = r_loading;
   assign bus.word_count   = r_word_count;
   assign bus.err_partial  = r_err_partial;
   assign bus.err_overflow = r_err_overflow;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: expected memory writes are queued as bytes are sent
// and popped by a write monitor; per-scenario tasks check status outputs.
module tb_prog_load_ctrl;
   localparam int W = 2;

   typedef struct {
      logic [W-1:0] addr;
      logic [31:0]  data;
   } wr_t;

   logic CLK = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;
   wr_t  sb[$];

   prog_load_if #(.INST_MEM_WIDTH(W)) bus();

   prog_load_ctrl #(.INST_MEM_WIDTH(W)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Every cycle with mem_we high must match the oldest queued write
   always @(negedge CLK) begin
      if (bus.mem_we === 1'b1) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", bus.mem_addr, bus.mem_wdata);
         end else begin
            wr_t e;
            e = sb.pop_front();
            if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
               n_fail++;
               $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                        bus.mem_addr, bus.mem_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic cyc(input logic s, input logic e, input logic v, input logic [7:0] d);
      bus.input_start = s;
      bus.input_end   = e;
      bus.input_valid = v;
      bus.input_data  = d;
      @(posedge CLK); #1;
      bus.input_start = 1'b0;
      bus.input_end   = 1'b0;
      bus.input_valid = 1'b0;
   endtask

   task automatic push(input logic [W-1:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic check_sb_empty(input string name);
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_missing_writes: got %0d writes outstanding, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle(2);
      @(negedge CLK);
      n_cmp++;
      if ({bus.cpu_enable, bus.loading, bus.mem_we, bus.mem_addr, bus.mem_wdata,
           bus.word_count, bus.err_partial, bus.err_overflow} !== {1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: got cpu_en=%b loading=%b we=%b addr=%0d wdata=%h wc=%0d ep=%b eo=%b, required 1 0 0 0 0 0 0 0",
                  bus.cpu_enable, bus.loading, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                  bus.word_count, bus.err_partial, bus.err_overflow);
      end
      reset = 1'b0;
      idle(1);
   endtask

   task automatic test_basic;
      logic [7:0] b [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      cyc(1, 0, 0, 8'h00);
      @(negedge CLK);
      n_cmp++;
      if ({bus.cpu_enable, bus.loading} !== 2'b01) begin
         n_fail++;
         $display("FAIL basic_start_plus1: got cpu_en=%b loading=%b, required 0 1", bus.cpu_enable, bus.loading);
      end
      push(2'd0, 32'h12345678);
      push(2'd1, 32'h9ABCDEF0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, b[i]);
      cyc(0, 1, 0, 8'h00);
      @(negedge CLK);
      n_cmp++;
      if ({bus.cpu_enable, bus.loading} !== 2'b01) begin
         n_fail++;
         $display("FAIL basic_drain_cycle: got cpu_en=%b loading=%b, required 0 1", bus.cpu_enable, bus.loading);
      end
      idle(1);
      @(negedge CLK);
      n_cmp++;
      if ({bus.cpu_enable, bus.loading, bus.word_count, bus.err_partial, bus.err_overflow} !== {1'b1, 1'b0, 3'd2, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_end_plus2: got cpu_en=%b loading=%b wc=%0d ep=%b eo=%b, required 1 0 2 0 0",
                  bus.cpu_enable, bus.loading, bus.word_count, bus.err_partial, bus.err_overflow);
      end
      check_sb_empty("basic");
   endtask

   task automatic test_partial;
      logic [7:0] b [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      cyc(1, 0, 0, 8'h00);
      push(2'd0, 32'hAABBCCDD);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, b[i]);
      cyc(0, 1, 0, 8'h00);
      @(negedge CLK);
      n_cmp++;
      if (bus.err_partial !== 1'b0) begin
         n_fail++;
         $display("FAIL partial_flag_early: got err_partial=%b at end+1, required 0", bus.err_partial);
      end
      idle(1);
      @(negedge CLK);
      n_cmp++;
      if ({bus.err_partial, bus.err_overflow, bus.word_count, bus.cpu_enable} !== {1'b1, 1'b0, 3'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL partial_end_plus2: got ep=%b eo=%b wc=%0d cpu_en=%b, required 1 0 1 1",
                  bus.err_partial, bus.err_overflow, bus.word_count, bus.cpu_enable);
      end
      idle(3);
      @(negedge CLK);
      n_cmp++;
      if (bus.err_partial !== 1'b1) begin
         n_fail++;
         $display("FAIL partial_sticky: got err_partial=%b, required 1", bus.err_partial);
      end
      check_sb_empty("partial");
   endtask

   task automatic test_overflow;
      cyc(1, 0, 0, 8'h00);
      for (int w = 0; w < 4; w++)
         push(W'(w), {8'(8'h40 + 4*w), 8'(8'h41 + 4*w), 8'(8'h42 + 4*w), 8'(8'h43 + 4*w)});
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 8'(8'h40 + i));
      cyc(0, 1, 0, 8'h00);
      idle(1);
      @(negedge CLK);
      n_cmp++;
      if ({bus.err_overflow, bus.err_partial, bus.word_count, bus.cpu_enable} !== {1'b1, 1'b0, 3'd4, 1'b1}) begin
         n_fail++;
         $display("FAIL overflow_status: got eo=%b ep=%b wc=%0d cpu_en=%b, required 1 0 4 1",
                  bus.err_overflow, bus.err_partial, bus.word_count, bus.cpu_enable);
      end
      check_sb_empty("overflow");
   endtask

   task automatic test_end_with_fourth;
      cyc(1, 0, 0, 8'h00);
      push(2'd0, 32'h01020304);
      cyc(0, 0, 1, 8'h01);
      cyc(0, 0, 1, 8'h02);
      cyc(0, 0, 1, 8'h03);
      cyc(0, 1, 1, 8'h04);
      @(negedge CLK);
      n_cmp++;
      if ({bus.mem_we, bus.loading, bus.cpu_enable} !== 3'b110) begin
         n_fail++;
         $display("FAIL end_fourth_drain_write: got we=%b loading=%b cpu_en=%b, required 1 1 0",
                  bus.mem_we, bus.loading, bus.cpu_enable);
      end
      idle(1);
      @(negedge CLK);
      n_cmp++;
      if ({bus.word_count, bus.err_partial, bus.cpu_enable} !== {3'd1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL end_fourth_status: got wc=%0d ep=%b cpu_en=%b, required 1 0 1",
                  bus.word_count, bus.err_partial, bus.cpu_enable);
      end
      check_sb_empty("end_fourth");
   endtask

   task automatic test_restart;
      cyc(1, 0, 0, 8'h00);
      cyc(0, 0, 1, 8'hA1);
      cyc(0, 0, 1, 8'hA2);
      cyc(0, 0, 1, 8'hA3);
      cyc(1, 1, 1, 8'hFF);
      idle(1);
      @(negedge CLK);
      n_cmp++;
      if ({bus.loading, bus.cpu_enable, bus.word_count, bus.err_partial} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL restart_no_drain: got loading=%b cpu_en=%b wc=%0d ep=%b, required 1 0 0 0",
                  bus.loading, bus.cpu_enable, bus.word_count, bus.err_partial);
      end
      push(2'd0, 32'h11223344);
      cyc(0, 0, 1, 8'h11);
      cyc(0, 0, 1, 8'h22);
      cyc(0, 0, 1, 8'h33);
      cyc(0, 0, 1, 8'h44);
      cyc(0, 1, 0, 8'h00);
      idle(1);
      @(negedge CLK);
      n_cmp++;
      if ({bus.word_count, bus.err_partial, bus.cpu_enable} !== {3'd1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL restart_status: got wc=%0d ep=%b cpu_en=%b, required 1 0 1",
                  bus.word_count, bus.err_partial, bus.cpu_enable);
      end
      check_sb_empty("restart");
   endtask

   task automatic test_reset_midload;
      cyc(1, 0, 0, 8'h00);
      push(2'd0, 32'hC0C1C2C3);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'(8'hC0 + i));
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if ({bus.cpu_enable, bus.loading, bus.mem_we, bus.mem_addr, bus.mem_wdata,
           bus.word_count, bus.err_partial, bus.err_overflow} !== {1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midload_reset_values: got cpu_en=%b loading=%b we=%b addr=%0d wdata=%h wc=%0d ep=%b eo=%b, required 1 0 0 0 0 0 0 0",
                  bus.cpu_enable, bus.loading, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                  bus.word_count, bus.err_partial, bus.err_overflow);
      end
      cyc(0, 0, 1, 8'hC6);
      cyc(0, 0, 1, 8'hC7);
      idle(3);
      check_sb_empty("midload_reset");
   endtask

   task automatic test_idle_noise;
      for (int i = 0; i < 6; i++) cyc(0, i[0], 1, 8'(8'h55 + i));
      cyc(0, 1, 0, 8'h00);
      idle(2);
      @(negedge CLK);
      n_cmp++;
      if ({bus.loading, bus.cpu_enable, bus.word_count, bus.err_partial} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL idle_noise: got loading=%b cpu_en=%b wc=%0d ep=%b, required 0 1 0 0",
                  bus.loading, bus.cpu_enable, bus.word_count, bus.err_partial);
      end
   endtask

   initial begin
      bus.input_start = 1'b0;
      bus.input_end   = 1'b0;
      bus.input_valid = 1'b0;
      bus.input_data  = 8'h00;
      test_reset();
      test_basic();
      test_partial();
      test_overflow();
      test_end_with_fourth();
      test_restart();
      test_reset_midload();
      test_idle_noise();
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
